// File: rtl/bwt_pkg.sv
// Shared definitions for bus_write_tracer.
//   SRC_W          width of the source-code field in a trace entry
//   SRC_R0..SRC_G  source codes: R0..R7 = 0..7, A = 8, G = 9
//   TS_EN          1 when built with BWT_TIMESTAMP_EN (timestamped entries)
//   entry_w()      total trace entry width for a given data / timestamp width
package bwt_pkg;

`ifdef BWT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int SRC_W = 4;

  localparam logic [SRC_W-1:0] SRC_R0 = 4'd0;
  localparam logic [SRC_W-1:0] SRC_R1 = 4'd1;
  localparam logic [SRC_W-1:0] SRC_R2 = 4'd2;
  localparam logic [SRC_W-1:0] SRC_R3 = 4'd3;
  localparam logic [SRC_W-1:0] SRC_R4 = 4'd4;
  localparam logic [SRC_W-1:0] SRC_R5 = 4'd5;
  localparam logic [SRC_W-1:0] SRC_R6 = 4'd6;
  localparam logic [SRC_W-1:0] SRC_R7 = 4'd7;
  localparam logic [SRC_W-1:0] SRC_A  = 4'd8;
  localparam logic [SRC_W-1:0] SRC_G  = 4'd9;

  // Entry layout is {ts (optional), src, data}.
  function automatic int entry_w(input int data_w, input int ts_w);
    return (TS_EN ? ts_w : 0) + SRC_W + data_w;
  endfunction

endpackage

// File: rtl/bwt_fifo.sv
// Synchronous FIFO holding trace entries.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push         request to store push_data (accepted when not full, or when
//                a pop happens in the same cycle)
//   push_data    entry to store
//   pop          request to drop the head entry (ignored when empty)
//   rd_data      head entry; zero when empty
//   full, empty  occupancy status
//   level        occupancy 0..DEPTH
module bwt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Head is only meaningful when occupied; present zero otherwise so the
  // output is clean after reset without clearing the storage array.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bus_write_tracer.sv
// Passive observer of register writes on the processor datapath. Every
// captured write becomes a {src, data} entry (optionally prefixed by a cycle
// timestamp) in an internal FIFO that a host drains with valid/ready.
// Build option: define BWT_TIMESTAMP_EN to add a TS_W-bit capture timestamp.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus, g      write data sources (bus for R0..R7/A, g for G)
//   reg_in      R write enables, bit7=R0 .. bit0=R7
//   a_in, g_in  A and G write enables
//   cap_en      capture enable; pops continue while low
//   rd_valid    head entry available
//   rd_ready    host takes the head entry
//   rd_data     head entry
//   level       FIFO occupancy
//   overflow    sticky: a write was dropped because the FIFO was full
//   multi_err   sticky: several write strobes in one cycle
module bus_write_tracer
  import bwt_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 bus,
  input  logic [DATA_W-1:0]                 g,
  input  logic [7:0]                        reg_in,
  input  logic                              a_in,
  input  logic                              g_in,
  input  logic                              cap_en,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [entry_w(DATA_W, TS_W)-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]            level,
  output logic                              overflow,
  output logic                              multi_err
);

  localparam int ENTRY_W = entry_w(DATA_W, TS_W);

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               strobe_multi;
  logic [SRC_W-1:0]   src;
  logic [DATA_W-1:0]  data;
  logic [ENTRY_W-1:0] entry;

  // Strobe priority: G > A > R0 > ... > R7; losing strobes are discarded.
  always_comb begin
    push         = cap_en & (g_in | a_in | (|reg_in));
    strobe_multi = cap_en & ($countones({g_in, a_in, reg_in}) > 1);
    src          = SRC_R0;
    data         = bus;
    if (g_in) begin
      src  = SRC_G;
      data = g;
    end else if (a_in) begin
      src  = SRC_A;
    end else begin
      casez (reg_in)
        8'b1???????: src = SRC_R0;
        8'b01??????: src = SRC_R1;
        8'b001?????: src = SRC_R2;
        8'b0001????: src = SRC_R3;
        8'b00001???: src = SRC_R4;
        8'b000001??: src = SRC_R5;
        8'b0000001?: src = SRC_R6;
        8'b00000001: src = SRC_R7;
        default:     src = SRC_R0;
      endcase
    end
  end

`ifdef BWT_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  assign entry = {ts, src, data};
`else
  assign entry = {src, data};
`endif

  assign pop      = rd_ready & ~empty;
  assign rd_valid = ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      if (push & full & ~pop) begin
        overflow <= 1'b1;
      end
      if (strobe_multi) begin
        multi_err <= 1'b1;
      end
    end
  end

  bwt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule
